// File: rtl/and_tree_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined AND tree.
package and_tree_pkg;

    localparam int unsigned HIT_CNT_W = 16;

    localparam string REAL_BEHAV = "behav";
    localparam string REAL_KMOP  = "kmop";

    // Number of 3:1 tree levels needed to reduce n bits to one, at least 1.
    function automatic int unsigned clog3(input int unsigned n);
        int unsigned s;
        int unsigned p;
        s = 1;
        p = 3;
        while (p < n) begin
            p = p * 3;
            s = s + 1;
        end
        return s;
    endfunction

    // Registered bits held by level k: ceil(w / 3^(k+1)).
    function automatic int unsigned level_width(input int unsigned w, input int unsigned k);
        int unsigned p;
        p = 3;
        for (int unsigned i = 0; i < k; i++) begin
            p = p * 3;
        end
        return (w + p - 1) / p;
    endfunction

    // Bit offset of level k inside the flattened level register vector.
    function automatic int unsigned level_offset(input int unsigned w, input int unsigned k);
        int unsigned off;
        off = 0;
        for (int unsigned j = 0; j < k; j++) begin
            off = off + level_width(w, j);
        end
        return off;
    endfunction

endpackage

// File: rtl/and_tree_pipe_if.sv
// Valid/ready input and output channels of the pipelined AND tree.
interface and_tree_pipe_if #(
    parameter int unsigned WIDTH = 9
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_y;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_y
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_y
    );
endinterface

// File: rtl/and_tree_pipe_and3_cell.sv
// 3-input AND leaf: behavioural reduction or a switch-level CMOS NAND3 plus inverter.
module and3_cell
    import and_tree_pkg::*;
#(
    parameter string REALIZATION = REAL_BEHAV
) (
    input  logic [2:0] a,
    output logic       y
);

    if (REALIZATION == REAL_BEHAV) begin : g_behav
        assign y = &a;
    end else if (REALIZATION == REAL_KMOP) begin : g_kmop
        supply0 gnd;
        supply1 vdd;
        wire    nand_n;
        wire    n1;
        wire    n2;
        wire    y_sw;

        // Parallel pull-ups, series pull-down chain from gnd up to the NAND node.
        pmos p0 (nand_n, vdd, a[0]);
        pmos p1 (nand_n, vdd, a[1]);
        pmos p2 (nand_n, vdd, a[2]);
        nmos m2 (n2, gnd, a[2]);
        nmos m1 (n1, n2, a[1]);
        nmos m0 (nand_n, n1, a[0]);

        pmos p3 (y_sw, vdd, nand_n);
        nmos m3 (y_sw, gnd, nand_n);

        assign y = y_sw;
    end else begin : g_bad_realization
        $error("and3_cell: REALIZATION must be \"behav\" or \"kmop\"");
    end

endmodule

// File: rtl/and_tree_pipe.sv
// Pipelined N-input AND reduction built from registered levels of 3-input leaves.
// Optional saturating hit counter on output handshakes when AND_TREE_CNT_EN is defined.
module and_tree_pipe
    import and_tree_pkg::*;
#(
    parameter int unsigned WIDTH       = 9,
    parameter string       REALIZATION = REAL_BEHAV
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef AND_TREE_CNT_EN
    output logic [HIT_CNT_W-1:0] hit_cnt,
`endif
    and_tree_pipe_if.slave       bus
);

    localparam int unsigned STAGES = clog3(WIDTH);
    localparam int unsigned TOTW   = level_offset(WIDTH, STAGES);
    // Data registers reset to 1; the top bit is the final level and drives out_y, which resets to 0.
    localparam logic [TOTW-1:0] LVL_RST = ~(TOTW'(1) << (TOTW - 1));

    if (WIDTH < 1 || WIDTH > 243) begin : g_bad_width
        $error("and_tree_pipe: WIDTH must be within 1..243");
    end

    logic [TOTW-1:0]   lvl_q;
    logic [TOTW-1:0]   lvl_d;
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    logic              en_c;

    assign en_c          = !vld_q[STAGES-1] || bus.out_ready;
    assign bus.in_ready  = en_c;
    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.out_y     = lvl_q[TOTW-1];

    // One generate block per level: pad the source level with ones and reduce it 3:1.
    for (genvar k = 0; k < STAGES; k++) begin : g_lvl
        localparam int unsigned LW  = level_width(WIDTH, k);
        localparam int unsigned OFF = level_offset(WIDTH, k);
        localparam int unsigned SW  = (k == 0) ? WIDTH : level_width(WIDTH, (k == 0) ? 0 : k - 1);
        localparam int unsigned PO  = (k == 0) ? 0 : level_offset(WIDTH, (k == 0) ? 0 : k - 1);

        logic [SW-1:0]   src;
        logic [3*LW-1:0] src_pad;

        if (k == 0) begin : g_first
            assign src = bus.in_data;
        end else begin : g_next
            assign src = lvl_q[PO +: SW];
        end

        always_comb begin
            src_pad         = '1;
            src_pad[SW-1:0] = src;
        end

        for (genvar i = 0; i < LW; i++) begin : g_cell
            and3_cell #(
                .REALIZATION (REALIZATION)
            ) u_cell (
                .a (src_pad[3*i +: 3]),
                .y (lvl_d[OFF + i])
            );
        end
    end

    always_comb begin
        vld_d    = vld_q << 1;
        vld_d[0] = bus.in_valid;
    end

    // All levels move together whenever the output slot is free or being drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q <= LVL_RST;
            vld_q <= '0;
        end else if (en_c) begin
            lvl_q <= lvl_d;
            vld_q <= vld_d;
        end
    end

`ifdef AND_TREE_CNT_EN
    logic [HIT_CNT_W-1:0] hit_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q <= '0;
        end else if (vld_q[STAGES-1] && bus.out_ready && lvl_q[TOTW-1] && (hit_q != '1)) begin
            hit_q <= hit_q + HIT_CNT_W'(1);
        end
    end

    assign hit_cnt = hit_q;
`endif

endmodule

// File: doc/and_tree_pipe.md
# and_tree_pipe

Parametrised N-input AND reduction built from 3-input leaf cells arranged as a pipelined tree, with a valid/ready handshake on both sides. Each tree level is registered, so wide reductions close timing. The leaf cell is selectable between a behavioural model and a switch-level CMOS model. It sits in the education/ModelSim gate-library area as the sequential, width-generic generation of the 3-input AND cells.

## Interface

- WIDTH, 9, number of AND inputs; legal range 1..243.
- REALIZATION, "behav", leaf cell model.
  - "behav": continuous `&` of 3 bits.
  - "kmop": CMOS NAND3 plus inverter from nmos/pmos primitives.
  - Any other value is a compile-time error.
- clk  input  1  rising-edge clock, sole clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  WIDTH  operand bits.
- out_valid  output  1  out_y holds a result.
- out_ready  input  1  downstream accepts out_y.
- out_y  output  1  AND of all WIDTH bits of the accepted word.
- hit_cnt  output  16  count of results with out_y=1 (present only under AND_TREE_CNT_EN).

## Operation

- STAGES = ceil(log3(WIDTH)), minimum 1. Examples: WIDTH=1 → 1, 3 → 1, 9 → 2, 10 → 3, 27 → 3.
- Level k (k=0..STAGES-1) holds ceil(WIDTH/3^(k+1)) registered bits plus one valid bit.
  - Each register bit is the output of one leaf cell fed by three bits of the previous level.
- Missing leaf inputs (the tail of a non-multiple-of-3 level) are tied to 1, so padding never forces 0.
- Global advance enable: en = !out_valid || out_ready. On en, every level captures from the level below, and level 0 captures from in_data/in_valid.
- in_ready = en, combinational from out_valid and out_ready. A transfer occurs when in_valid && in_ready.
- Bubbles are not compressed. An empty stage advances only when en=1.
- out_y and out_valid are the last level's registers. out_y is held stable while out_valid && !out_ready.
- With "kmop", leaf outputs must be strong 0/1 for all 0/1 inputs.
  - An X/Z on an input may propagate as X.
  - Registers capture whatever the leaf drives.

## Timing

- Reset (rst_n=0, asynchronous): all valid bits 0, all data registers 1, out_y=0, hit_cnt=0.
  - Outputs take reset values immediately, without waiting for a clock edge.
  - Reset mid-operation discards every in-flight word; no partial result appears.
- Release is synchronous to clk. The first accept is possible on the first rising edge with rst_n=1.
- Latency is STAGES cycles: a word accepted on edge n gives out_valid=1 with its result after edge n+STAGES-1.
  - This assumes no stall in between; each stalled cycle adds exactly one.
- Throughput is one word per cycle while out_ready=1.
- Simultaneous pop and push (out_valid && out_ready && in_valid) is a lossless full-rate transfer.
- out_valid does not drop while out_ready=0.

## Configuration

- AND_TREE_CNT_EN defined:
  - hit_cnt port exists.
  - It increments on each output handshake (out_valid && out_ready) with out_y=1.
  - It saturates at 16'hFFFF and clears only on reset.
- AND_TREE_CNT_EN undefined: the port and counter logic are absent. Datapath behaviour is identical.

## Structure

- Package and_tree_pkg:
  - function clog3(int) returning STAGES.
  - function level_width(WIDTH, k).
  - string constants REAL_BEHAV="behav" and REAL_KMOP="kmop".
  - localparam HIT_CNT_W=16.
- Sub-module and3_cell (REALIZATION parameter, inputs a[2:0], output y).
  - It holds the "behav"/"kmop" generate split.
  - Tree generation instantiates it per leaf.
  - Pipeline registers and handshake logic stay in and_tree_pipe.

## Test plan

- Reset mid-run, WIDTH=9, REALIZATION="kmop":
  - Stimulus: push 9'h1FF, then assert rst_n=0 between the two edges.
  - Required: out_valid=0, out_y=0 immediately, and no result ever appears for that word.
- Latency, WIDTH=9:
  - Stimulus: push 9'h1FF at edge 0, then 9'h1FE at edge 1, with out_ready=1.
  - Required: out_y=1 valid after edge 1, out_y=0 after edge 2.
- Padding, WIDTH=10:
  - Stimulus: push 10'h3FF.
  - Required: out_y=1 after 3 cycles. 10'h1FF yields 0.
- Backpressure, WIDTH=27:
  - Stimulus: stream 5 words alternating all-ones/all-zeros, and hold out_ready=0 for 4 cycles mid-stream.
  - Required: in_ready=0 during the stall, no loss or duplication, and the output order is 1,0,1,0,1.
- Realization equivalence:
  - Stimulus: random 500 words at WIDTH=9 through both REALIZATION values in parallel.
  - Required: bit-identical out_y/out_valid sequences.
- AND_TREE_CNT_EN:
  - Stimulus: push 70000 all-ones words.
  - Required: hit_cnt saturates at 16'hFFFF.
  - Also: all-zero words never increment it, and hit_cnt=0 after reset.
